// File: rtl/pcsp_memory_sequencer_if.sv
// Control bundle between the PC/SP/memory sequencer and its datapath/decoder.
// The master side is the sequencer; the slave side is the datapath plus decoder.
interface pcsp_memory_sequencer_if;
  logic        hold;
  logic        run;
  logic [2:0]  op_class;
  logic        ld_long;
  logic [2:0]  jmp_pcsrc;
  logic [2:0]  st_dst;
  logic        MemWrite;
  logic [1:0]  MemSrc;
  logic [2:0]  MemDst;
  logic        InstWrite;
  logic        PCWrite;
  logic [2:0]  PCSrc;
  logic        SPWrite;
  logic [2:0]  SPSrc;
  logic        PCReset;
  logic        SPReset;
  logic        reg_write;
  logic        ra_write;
  logic        retire;
  logic        halted;
  logic [15:0] retired_cnt;
  logic [2:0]  fsm_state;

  modport master (
    input  hold, run, op_class, ld_long, jmp_pcsrc, st_dst,
    output MemWrite, MemSrc, MemDst, InstWrite, PCWrite, PCSrc, SPWrite, SPSrc,
           PCReset, SPReset, reg_write, ra_write, retire, halted, retired_cnt, fsm_state
  );

  modport slave (
    output hold, run, op_class, ld_long, jmp_pcsrc, st_dst,
    input  MemWrite, MemSrc, MemDst, InstWrite, PCWrite, PCSrc, SPWrite, SPSrc,
           PCReset, SPReset, reg_write, ra_write, retire, halted, retired_cnt, fsm_state
  );
endinterface

// File: rtl/pcsp_memory_sequencer.sv
// Multicycle control FSM for the PC/SP/memory block: fetch, decode, load/store,
// push/pop, jump/call and halt, with a retired-instruction counter.
module pcsp_memory_sequencer (
  input logic                     clock,
  input logic                     reset,
  pcsp_memory_sequencer_if.master bus
);
  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_LD_WB  = 3'd4;
  localparam logic [2:0] S_SP_DEC = 3'd5;
  localparam logic [2:0] S_MEM_WR = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [2:0] OP_ALU   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_JUMP  = 3'd5;
  localparam logic [2:0] OP_CALL  = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [1:0] MSRC_PC = 2'd0;
  localparam logic [1:0] MSRC_SP = 2'd1;
  localparam logic [1:0] MSRC_ZE = 2'd2;
  localparam logic [1:0] MSRC_LS = 2'd3;
  localparam logic [2:0] SPSRC_HOLD = 3'd0;
  localparam logic [2:0] SPSRC_DEC  = 3'd1;
  localparam logic [2:0] SPSRC_INC  = 3'd2;
  localparam logic [2:0] PCSRC_INC  = 3'd0;

  logic [2:0]  state, state_nxt;
  logic [2:0]  op_q;
  logic        ld_q;
  logic [15:0] cnt;

  logic       mem_write, inst_write, pc_write, sp_write, pc_reset, sp_reset;
  logic       reg_wr, ra_wr, ret;
  logic [1:0] mem_src, ls_src;
  logic [2:0] mem_dst, pc_src, sp_src;
  logic       live;

  assign ls_src = ld_q ? MSRC_LS : MSRC_ZE;

  always_comb begin
    state_nxt  = state;
    mem_write  = 1'b0;
    inst_write = 1'b0;
    pc_write   = 1'b0;
    sp_write   = 1'b0;
    pc_reset   = 1'b0;
    sp_reset   = 1'b0;
    reg_wr     = 1'b0;
    ra_wr      = 1'b0;
    ret        = 1'b0;
    mem_src    = MSRC_PC;
    mem_dst    = 3'd0;
    pc_src     = PCSRC_INC;
    sp_src     = SPSRC_HOLD;
    case (state)
      S_INIT: begin
        pc_reset  = 1'b1;
        sp_reset  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        inst_write = 1'b1;
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        case (bus.op_class)
          OP_ALU:   begin pc_write = 1'b1; ret = 1'b1; state_nxt = S_FETCH; end
          OP_LOAD:  state_nxt = S_MEM_RD;
          OP_STORE: state_nxt = S_MEM_WR;
          OP_PUSH:  state_nxt = S_SP_DEC;
          OP_POP:   state_nxt = S_MEM_RD;
          OP_JUMP: begin
            pc_write = 1'b1; pc_src = bus.jmp_pcsrc; ret = 1'b1; state_nxt = S_FETCH;
          end
          OP_CALL: begin
            ra_wr = 1'b1; pc_write = 1'b1; pc_src = bus.jmp_pcsrc; ret = 1'b1;
            state_nxt = S_FETCH;
          end
          default: begin ret = 1'b1; state_nxt = S_HALT; end
        endcase
      end
      S_MEM_RD: begin
        mem_src   = (op_q == OP_POP) ? MSRC_SP : ls_src;
        state_nxt = S_LD_WB;
      end
      S_LD_WB: begin
        reg_wr   = 1'b1;
        pc_write = 1'b1;
        ret      = 1'b1;
        if (op_q == OP_POP) begin
          sp_write = 1'b1;
          sp_src   = SPSRC_INC;
        end
        state_nxt = S_FETCH;
      end
      S_SP_DEC: begin
        sp_write  = 1'b1;
        sp_src    = SPSRC_DEC;
        state_nxt = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        mem_dst   = bus.st_dst;
        mem_src   = (op_q == OP_PUSH) ? MSRC_SP : ls_src;
        pc_write  = 1'b1;
        ret       = 1'b1;
        state_nxt = S_FETCH;
      end
      default: begin
        if (bus.run) state_nxt = S_FETCH;
      end
    endcase
  end

  // Outputs are all zero while reset is low even though the FSM already sits in INIT.
  assign live = reset && !bus.hold;

  assign bus.MemWrite    = mem_write  & live;
  assign bus.InstWrite   = inst_write & live;
  assign bus.PCWrite     = pc_write   & live;
  assign bus.SPWrite     = sp_write   & live;
  assign bus.PCReset     = pc_reset   & live;
  assign bus.SPReset     = sp_reset   & live;
  assign bus.reg_write   = reg_wr     & live;
  assign bus.ra_write    = ra_wr      & live;
  assign bus.retire      = ret        & live;
  assign bus.MemDst      = live  ? mem_dst : 3'd0;
  assign bus.MemSrc      = reset ? mem_src : MSRC_PC;
  assign bus.PCSrc       = reset ? pc_src  : PCSRC_INC;
  assign bus.SPSrc       = reset ? sp_src  : SPSRC_HOLD;
  assign bus.halted      = reset && (state == S_HALT);
  assign bus.retired_cnt = cnt;
  assign bus.fsm_state   = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
      op_q  <= OP_ALU;
      ld_q  <= 1'b0;
      cnt   <= 16'd0;
    end else if (!bus.hold) begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        op_q <= bus.op_class;
        ld_q <= bus.ld_long;
      end
      if (ret) cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pcsp_memory_sequencer.sv
// Directed bench for pcsp_memory_sequencer: walks each op class cycle by cycle
// and compares every control output against hand-computed values.
module tb_pcsp_memory_sequencer;
  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pcsp_memory_sequencer_if bus ();

  pcsp_memory_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected control word, field order:
  // MemWrite MemSrc MemDst InstWrite PCWrite PCSrc SPWrite SPSrc PCReset SPReset reg_write ra_write retire halted
  task automatic expect_ctl(input string tag, input logic mw, input logic [1:0] ms,
                            input logic [2:0] md, input logic iw, input logic pw,
                            input logic [2:0] ps, input logic sw, input logic [2:0] ss,
                            input logic pr, input logic sr, input logic rw,
                            input logic ra, input logic rt, input logic hl);
    logic [20:0] obs, exp;
    obs = {bus.MemWrite, bus.MemSrc, bus.MemDst, bus.InstWrite, bus.PCWrite, bus.PCSrc,
           bus.SPWrite, bus.SPSrc, bus.PCReset, bus.SPReset, bus.reg_write, bus.ra_write,
           bus.retire, bus.halted};
    exp = {mw, ms, md, iw, pw, ps, sw, ss, pr, sr, rw, ra, rt, hl};
    check_eq(tag, {11'd0, obs}, {11'd0, exp});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  // Mutual-exclusion rules hold on every cycle out of reset.
  always @(negedge clock) begin
    if (reset)
      check_eq("excl", {30'd0, bus.MemWrite & bus.InstWrite, bus.SPWrite & bus.PCReset}, 32'd0);
  end

  initial begin
    reset         = 1'b0;
    bus.hold      = 1'b0;
    bus.run       = 1'b0;
    bus.op_class  = 3'd0;
    bus.ld_long   = 1'b0;
    bus.jmp_pcsrc = 3'd0;
    bus.st_dst    = 3'd0;

    repeat (3) begin
      step(); look();
      expect_ctl("reset_out", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      check_eq("reset_cnt", {16'd0, bus.retired_cnt}, 32'd0);
    end
    step(); reset = 1'b1; look();
    expect_ctl("init", 0,0,0,0,0,0,0,0,1,1,0,0,0,0);
    step(); look();
    expect_ctl("fetch0", 0,0,0,1,0,0,0,0,0,0,0,0,0,0);
    check_eq("cnt_start", {16'd0, bus.retired_cnt}, 32'd0);

    // Three ALU instructions, two cycles each
    bus.op_class = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step(); look();
      expect_ctl("alu_dec", 0,0,0,0,1,0,0,0,0,0,0,0,1,0);
      step(); look();
      expect_ctl("alu_fetch", 0,0,0,1,0,0,0,0,0,0,0,0,0,0);
    end
    check_eq("cnt_alu", {16'd0, bus.retired_cnt}, 32'd3);

    // PUSH: op_class changed after DECODE must not matter
    bus.op_class = 3'd3; bus.st_dst = 3'd2;
    step(); look();
    expect_ctl("push_dec", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); bus.op_class = 3'd0; look();
    expect_ctl("push_spdec", 0,0,0,0,0,0,1,1,0,0,0,0,0,0);
    step(); look();
    expect_ctl("push_wr", 1,1,2,0,1,0,0,0,0,0,0,0,1,0);
    step(); look();
    expect_ctl("push_fetch", 0,0,0,1,0,0,0,0,0,0,0,0,0,0);
    check_eq("cnt_push", {16'd0, bus.retired_cnt}, 32'd4);

    // POP
    bus.op_class = 3'd4;
    step(); look();
    expect_ctl("pop_dec", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); look();
    expect_ctl("pop_rd", 0,1,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); look();
    expect_ctl("pop_wb", 0,0,0,0,1,0,1,2,0,0,1,0,1,0);
    step(); look();
    check_eq("cnt_pop", {16'd0, bus.retired_cnt}, 32'd5);

    // LOAD long with hold in MEM_RD and LD_WB; ld_long drop after DECODE ignored
    bus.op_class = 3'd1; bus.ld_long = 1'b1;
    step(); look();
    expect_ctl("ld_dec", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); bus.hold = 1'b1; bus.ld_long = 1'b0; look();
    expect_ctl("ld_hold1", 0,3,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); look();
    expect_ctl("ld_hold2", 0,3,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); bus.hold = 1'b0; look();
    expect_ctl("ld_rd", 0,3,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); bus.hold = 1'b1; look();
    expect_ctl("ld_wb_hold", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); look();
    check_eq("cnt_hold", {16'd0, bus.retired_cnt}, 32'd5);
    step(); bus.hold = 1'b0; look();
    expect_ctl("ld_wb", 0,0,0,0,1,0,0,0,0,0,1,0,1,0);
    step(); look();
    expect_ctl("ld_fetch", 0,0,0,1,0,0,0,0,0,0,0,0,0,0);
    check_eq("cnt_load", {16'd0, bus.retired_cnt}, 32'd6);

    // CALL and JUMP pass jmp_pcsrc through
    bus.op_class = 3'd6; bus.jmp_pcsrc = 3'd5;
    step(); look();
    expect_ctl("call_dec", 0,0,0,0,1,5,0,0,0,0,0,1,1,0);
    step(); look();
    bus.op_class = 3'd5; bus.jmp_pcsrc = 3'd3;
    step(); look();
    expect_ctl("jump_dec", 0,0,0,0,1,3,0,0,0,0,0,0,1,0);
    step(); look();
    check_eq("cnt_jmp", {16'd0, bus.retired_cnt}, 32'd8);

    // STORE short address
    bus.op_class = 3'd2; bus.ld_long = 1'b0; bus.st_dst = 3'd4;
    step(); look();
    expect_ctl("st_dec", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); look();
    expect_ctl("st_wr", 1,2,4,0,1,0,0,0,0,0,0,0,1,0);
    step(); look();
    check_eq("cnt_store", {16'd0, bus.retired_cnt}, 32'd9);

    // HALT, then run under hold is lost, then run alone resumes
    bus.op_class = 3'd7;
    step(); look();
    expect_ctl("halt_dec", 0,0,0,0,0,0,0,0,0,0,0,0,1,0);
    step(); bus.run = 1'b1; bus.hold = 1'b1; look();
    expect_ctl("halt_hold_run", 0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    check_eq("cnt_halt", {16'd0, bus.retired_cnt}, 32'd10);
    step(); bus.run = 1'b0; bus.hold = 1'b0; look();
    expect_ctl("halt_stay", 0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    step(); bus.run = 1'b1; look();
    expect_ctl("halt_run", 0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    step(); bus.run = 1'b0; look();
    expect_ctl("resume_fetch", 0,0,0,1,0,0,0,0,0,0,0,0,0,0);
    check_eq("cnt_resume", {16'd0, bus.retired_cnt}, 32'd10);

    // Reset asserted in the DECODE cycle of a STORE
    bus.op_class = 3'd2; bus.st_dst = 3'd1;
    step(); look();
    expect_ctl("st2_dec", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    #2 reset = 1'b0;
    #1;
    expect_ctl("st2_reset", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    check_eq("cnt_cleared", {16'd0, bus.retired_cnt}, 32'd0);
    step(); look();
    expect_ctl("st2_in_reset", 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    step(); reset = 1'b1; look();
    expect_ctl("reinit", 0,0,0,0,0,0,0,0,1,1,0,0,0,0);
    step(); look();
    expect_ctl("refetch", 0,0,0,1,0,0,0,0,0,0,0,0,0,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
